// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage: op codes, RV32I opcode/funct7
// values and the registered issue entry.
package alu_pkg;

  localparam int ISSUE_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_AND  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [ISSUE_XLEN-1:0] operand_a;
    logic [ISSUE_XLEN-1:0] operand_b;
    alu_op_e               alu_op;
    logic [4:0]            rd_addr;
    logic                  rd_we;
    logic                  illegal;
    logic [ISSUE_XLEN-1:0] pc;
  } issue_entry_t;

  // funct3 mapping shared by OP and OP-IMM with funct7 = 0000000.
  function automatic alu_op_e base_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode of one instruction into an ALU issue entry
// (operands, op, destination, writeback enable, illegal flag, pc).
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [ISSUE_XLEN-1:0] instr,
  input  logic [ISSUE_XLEN-1:0] pc,
  input  logic [ISSUE_XLEN-1:0] rs1_data,
  input  logic [ISSUE_XLEN-1:0] rs2_data,
  output issue_entry_t          entry
);

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [4:0]            rd;
  logic [ISSUE_XLEN-1:0] imm_i, imm_s, imm_u;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};

  logic [ISSUE_XLEN-1:0] op_a, op_b;
  alu_op_e               op;
  logic                  we, illegal;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    op_a    = '0;
    op_b    = '0;
    op      = ALU_ADD;
    we      = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        op_a = rs1_data;
        op_b = rs2_data;
        we   = 1'b1;
        if (funct7 == F7_BASE)                         op = base_op(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000) op = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101) op = ALU_SRA;
        else                                           illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        op_a = rs1_data;
        op_b = imm_i;
        we   = 1'b1;
        op   = base_op(funct3);
        // Shift-immediate forms reuse imm[11:5] as funct7.
        if (funct3 == 3'b001 && funct7 != F7_BASE) illegal = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT)       op = ALU_SRA;
          else if (funct7 != F7_BASE) illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        op_b = imm_u;
        we   = 1'b1;
      end
      OPC_AUIPC: begin
        op_a = pc;
        op_b = imm_u;
        we   = 1'b1;
      end
      OPC_LOAD: begin
        op_a = rs1_data;
        op_b = imm_i;
        we   = 1'b1;
      end
      OPC_STORE: begin
        op_a = rs1_data;
        op_b = imm_s;
      end
      OPC_JAL, OPC_JALR: begin
        op_a = pc;
        op_b = 32'd4;
        we   = 1'b1;
      end
      OPC_BRANCH: begin
        op_a = rs1_data;
        op_b = rs2_data;
        case (funct3)
          3'b000, 3'b001: op = ALU_SUB;
          3'b100, 3'b101: op = ALU_SLT;
          3'b110, 3'b111: op = ALU_SLTU;
          default:        illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      op_a = '0;
      op_b = '0;
      op   = ALU_ADD;
      we   = 1'b0;
    end
    if (rd == 5'd0) we = 1'b0;
  end

  assign entry = '{operand_a: op_a, operand_b: op_b, alu_op: op, rd_addr: rd,
                   rd_we: we, illegal: illegal, pc: pc};

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue pipeline register with valid/ready, flush and illegal flagging.
// Define ALU_ISSUE_SKID_EN for a two-entry skid buffer with a registered o_ready.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_operand_a,
  output logic [XLEN-1:0] o_operand_b,
  output logic [3:0]      o_alu_op,
  output logic [4:0]      o_rd_addr,
  output logic            o_rd_we,
  output logic            o_illegal,
  output logic [XLEN-1:0] o_pc
);

  issue_entry_t dec_entry;
  issue_entry_t out_q;
  logic         out_valid;
  logic         in_xfer, out_xfer;

  alu_op_decode u_decode (
    .instr    (i_instr),
    .pc       (i_pc),
    .rs1_data (i_rs1_data),
    .rs2_data (i_rs2_data),
    .entry    (dec_entry)
  );

  assign in_xfer  = i_valid & o_ready;
  assign out_xfer = out_valid & i_ready;

`ifdef ALU_ISSUE_SKID_EN
  issue_entry_t skid_q;
  logic         skid_valid;
  logic         ready_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
      ready_q    <= 1'b0;
    end else if (i_flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      // ready_q tracks the next value of ~skid_valid.
      ready_q <= 1'b1;
      if (skid_valid) begin
        if (out_xfer) begin
          out_q      <= skid_q;
          skid_valid <= 1'b0;
        end else begin
          ready_q <= 1'b0;
        end
      end else if (!out_valid || out_xfer) begin
        out_valid <= in_xfer;
        if (in_xfer) out_q <= dec_entry;
      end else if (in_xfer) begin
        skid_q     <= dec_entry;
        skid_valid <= 1'b1;
        ready_q    <= 1'b0;
      end
    end
  end

  assign o_ready = ready_q;
`else
  logic ready_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the payload register is reset too, because every output must read 0 in reset.
      out_valid <= 1'b0;
      out_q     <= '0;
      ready_en  <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
      ready_en <= 1'b1;
      if (i_flush) begin
        out_valid <= 1'b0;
      end else if (!out_valid || out_xfer) begin
        out_valid <= in_xfer;
        if (in_xfer) out_q <= dec_entry;
      end
    end
  end

  assign o_ready = ready_en & (~out_valid | i_ready);
`endif

  assign o_valid     = out_valid;
  assign o_operand_a = out_q.operand_a;
  assign o_operand_b = out_q.operand_b;
  assign o_alu_op    = out_q.alu_op;
  assign o_rd_addr   = out_q.rd_addr;
  assign o_rd_we     = out_q.rd_we;
  assign o_illegal   = out_q.illegal;
  assign o_pc        = out_q.pc;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed RV32I cases plus randomized
// traffic against a queue-based reference model of the decode and handshake.
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk, rst_n;
  logic        i_valid, i_flush, i_ready;
  logic [31:0] i_instr, i_pc, i_rs1_data, i_rs2_data;
  logic        o_ready, o_valid, o_rd_we, o_illegal;
  logic [31:0] o_operand_a, o_operand_b, o_pc;
  logic [3:0]  o_alu_op;
  logic [4:0]  o_rd_addr;

  alu_issue_stage #(.XLEN(32)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_instr     (i_instr),
    .i_pc        (i_pc),
    .i_rs1_data  (i_rs1_data),
    .i_rs2_data  (i_rs2_data),
    .i_flush     (i_flush),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_operand_a (o_operand_a),
    .o_operand_b (o_operand_b),
    .o_alu_op    (o_alu_op),
    .o_rd_addr   (o_rd_addr),
    .o_rd_we     (o_rd_we),
    .o_illegal   (o_illegal),
    .o_pc        (o_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] a, b, pc;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        we, ill;
  } exp_t;

  exp_t q[$];
  bit   ready_en;

  // Reference decode written directly from the RV32I field rules.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t        e;
    int          base[8];
    logic [31:0] imm_i, imm_s, imm_u;
    logic [2:0]  f3;
    logic [6:0]  f7;
    base  = '{0, 7, 2, 3, 4, 8, 5, 6};
    f3    = ins[14:12];
    f7    = ins[31:25];
    imm_i = $signed(ins) >>> 20;
    imm_s = {imm_i[31:5], ins[11:7]};
    imm_u = ins & 32'hFFFF_F000;
    e.pc = pc; e.rd = ins[11:7];
    e.a = 0; e.b = 0; e.op = 0; e.we = 0; e.ill = 0;
    case (ins[6:0])
      7'h33: begin
        e.a = rs1; e.b = rs2; e.we = 1;
        if (f7 == 7'h00)                  e.op = 4'(base[f3]);
        else if (f7 == 7'h20 && f3 == 0)  e.op = 1;
        else if (f7 == 7'h20 && f3 == 5)  e.op = 9;
        else                              e.ill = 1;
      end
      7'h13: begin
        e.a = rs1; e.b = imm_i; e.we = 1; e.op = 4'(base[f3]);
        if (f3 == 1 && f7 != 0) e.ill = 1;
        if (f3 == 5 && f7 == 7'h20) e.op = 9;
        else if (f3 == 5 && f7 != 0) e.ill = 1;
      end
      7'h37: begin e.b = imm_u; e.we = 1; end
      7'h17: begin e.a = pc; e.b = imm_u; e.we = 1; end
      7'h03: begin e.a = rs1; e.b = imm_i; e.we = 1; end
      7'h23: begin e.a = rs1; e.b = imm_s; end
      7'h6F, 7'h67: begin e.a = pc; e.b = 4; e.we = 1; end
      7'h63: begin
        e.a = rs1; e.b = rs2;
        case (f3[2:1])
          2'd0:    e.op = 1;
          2'd2:    e.op = 2;
          2'd3:    e.op = 3;
          default: e.ill = 1;
        endcase
      end
      default: e.ill = 1;
    endcase
    if (e.ill) begin e.a = 0; e.b = 0; e.op = 0; e.we = 0; end
    if (e.rd == 0) e.we = 0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h37;
      3: w[6:0] = 7'h17;
      4: w[6:0] = 7'h03;
      5: w[6:0] = 7'h23;
      6: w[6:0] = 7'h6F;
      7: w[6:0] = 7'h67;
      8: w[6:0] = 7'h63;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0, 1: w[31:25] = 7'h00;
      2:    w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  task automatic check_outputs();
    check("o_valid", 32'(o_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check("operand_a", o_operand_a, q[0].a);
      check("operand_b", o_operand_b, q[0].b);
      check("alu_op",    32'(o_alu_op),  32'(q[0].op));
      check("rd_addr",   32'(o_rd_addr), 32'(q[0].rd));
      check("rd_we",     32'(o_rd_we),   32'(q[0].we));
      check("illegal",   32'(o_illegal), 32'(q[0].ill));
      check("pc",        o_pc, q[0].pc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_ready"}, 32'(o_ready), 32'd0);
    check({tag, "_a"},     o_operand_a, 32'd0);
    check({tag, "_b"},     o_operand_b, 32'd0);
    check({tag, "_op"},    32'(o_alu_op), 32'd0);
    check({tag, "_rd"},    32'(o_rd_addr), 32'd0);
    check({tag, "_we"},    32'(o_rd_we), 32'd0);
    check({tag, "_ill"},   32'(o_illegal), 32'd0);
    check({tag, "_pc"},    o_pc, 32'd0);
  endtask

  // One clock cycle: check held outputs, drive inputs, check o_ready, advance model.
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input bit fl, input bit rdy, output bit accepted);
    bit   exp_ready, out_x;
    exp_t e;
    check_outputs();
    i_valid = v; i_instr = ins; i_pc = pc; i_rs1_data = rs1; i_rs2_data = rs2;
    i_flush = fl; i_ready = rdy;
    #1;
    if (CAP == 2) exp_ready = ready_en && (q.size() < 2);
    else          exp_ready = ready_en && (q.size() == 0 || rdy);
    check("o_ready", 32'(o_ready), 32'(exp_ready));
    accepted = v && exp_ready && !fl;
    out_x    = (q.size() > 0) && rdy;
    e        = ref_decode(ins, pc, rs1, rs2);
    @(posedge clk);
    ready_en = 1'b1;
    if (fl) q.delete();
    else begin
      if (out_x) void'(q.pop_front());
      if (v && exp_ready) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    bit acc;
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, rdy, acc);
  endtask

  task automatic rand_step(input int flush_pct);
    bit acc;
    step(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom, $urandom,
         1'($urandom_range(0, 99) < flush_pct), 1'($urandom_range(0, 2) != 0), acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc, b_sent;
    rst_n = 1'b0;
    i_valid = 0; i_flush = 0; i_ready = 0;
    i_instr = 0; i_pc = 0; i_rs1_data = 0; i_rs2_data = 0;
    ready_en = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(1'b1);

    // ADD x3,x1,x2
    step(1, 32'h002081B3, 32'h100, 32'd5, 32'd7, 0, 1, acc);
    check("add_valid", 32'(o_valid), 32'd1);
    check("add_a", o_operand_a, 32'd5);
    check("add_b", o_operand_b, 32'd7);
    check("add_op", 32'(o_alu_op), 32'd0);
    check("add_rd", 32'(o_rd_addr), 32'd3);
    check("add_we", 32'(o_rd_we), 32'd1);

    // SRAI x5,x6,3
    step(1, 32'h40335293, 32'h104, 32'h8000_0000, 32'h0, 0, 1, acc);
    check("srai_op", 32'(o_alu_op), 32'd9);
    check("srai_shamt", 32'(o_operand_b[4:0]), 32'd3);
    check("srai_a", o_operand_a, 32'h8000_0000);
    check("srai_ill", 32'(o_illegal), 32'd0);

    // LUI x1,0x12345 then an undecodable word
    step(1, 32'h123450B7, 32'h108, 32'h1111, 32'h2222, 0, 1, acc);
    check("lui_a", o_operand_a, 32'd0);
    check("lui_b", o_operand_b, 32'h1234_5000);
    check("lui_op", 32'(o_alu_op), 32'd0);
    step(1, 32'hFFFF_FFFF, 32'h10C, 32'h1, 32'h2, 0, 1, acc);
    check("bad_ill", 32'(o_illegal), 32'd1);
    check("bad_we", 32'(o_rd_we), 32'd0);

    // BLTU x1,x2 and BEQ x1,x2
    step(1, 32'h0020E063, 32'h110, 32'd9, 32'd3, 0, 1, acc);
    check("bltu_op", 32'(o_alu_op), 32'd3);
    check("bltu_we", 32'(o_rd_we), 32'd0);
    step(1, 32'h00208063, 32'h114, 32'd9, 32'd3, 0, 1, acc);
    check("beq_op", 32'(o_alu_op), 32'd1);
    idle(1'b1);

    // Stall three cycles while offering two instructions; the second is held until taken.
    step(1, 32'h002081B3, 32'h200, 32'd11, 32'd22, 0, 0, acc);
    b_sent = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!b_sent) step(1, 32'h40208233, 32'h204, 32'd50, 32'd8, 0, (i == 2), b_sent);
      else         idle(i == 2);
    end
    for (int i = 0; i < 4 && !b_sent; i++)
      step(1, 32'h40208233, 32'h204, 32'd50, 32'd8, 0, 1, b_sent);
    check("stall_b_taken", 32'(b_sent), 32'd1);
    repeat (3) idle(1'b1);

    // Flush beats a same-cycle accept.
    step(1, 32'h002081B3, 32'h300, 32'd1, 32'd2, 0, 0, acc);
    step(1, 32'h00208063, 32'h304, 32'd1, 32'd2, 1, 0, acc);
    check("flush_valid", 32'(o_valid), 32'd0);

    for (int i = 0; i < 400; i++) rand_step(5);

    // Asynchronous reset with a held entry.
    step(1, 32'h002081B3, 32'h400, 32'd3, 32'd4, 0, 0, acc);
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    q.delete();
    ready_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) rand_step(3);
    repeat (3) idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
